// File: rtl/xgriscv_pkg.sv
// ---------------------------------------------------------------------------
// xgriscv_pkg
//
// Purpose:
//   Shared types and constants for the xgriscv run controller. Holds the run
//   FSM state encoding, the run status codes reported to the bench or board,
//   the ebreak encoding used as a program-end marker, and a helper that
//   resolves simultaneous termination events into a single status code.
//
// Contents:
//   run_state_e    IDLE / RUN / DONE
//   run_status_e   ST_NONE / ST_END / ST_HANG / ST_TIMEOUT
//   INSTR_EBREAK   32-bit ebreak encoding
//   pick_status()  priority resolution of end / timeout / hang
// ---------------------------------------------------------------------------
package xgriscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_END     = 2'b01,
    ST_HANG    = 2'b10,
    ST_TIMEOUT = 2'b11
  } run_status_e;

  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

  // Several termination conditions can be true in the same RUN cycle. A
  // program that reaches its end marker has succeeded even if the budget
  // ran out or the PC stalled on that very cycle, so end wins over timeout,
  // and timeout wins over hang. ST_NONE means keep running.
  function automatic run_status_e pick_status(
    input logic end_hit,
    input logic timeout_hit,
    input logic hang_hit
  );
    run_status_e result;
    result = ST_NONE;
    if (end_hit) begin
      result = ST_END;
    end else if (timeout_hit) begin
      result = ST_TIMEOUT;
    end else if (hang_hit) begin
      result = ST_HANG;
    end
    return result;
  endfunction

endpackage

// File: rtl/run_monitor_hang_detector.sv
// ---------------------------------------------------------------------------
// hang_detector
//
// Purpose:
//   Watches the core writeback PC during a run and flags a hang when the PC
//   has stayed at the same value for HANG_LIMIT consecutive RUN cycles. It
//   also keeps the PC seen on the most recent RUN cycle, which the run
//   monitor reports as last_pc.
//
// Ports:
//   clk      in   1     system clock, rising edge
//   reset    in   1     synchronous active-high reset
//   clear    in   1     run entry: zero the stable count, re-arm "first"
//   advance  in   1     high on every RUN cycle
//   pc_w     in   XLEN  core writeback PC
//   last_pc  out  XLEN  PC sampled on the most recent RUN cycle (registered)
//   hang     out  1     combinational pulse: this RUN cycle completes a hang
// ---------------------------------------------------------------------------
module hang_detector
  import xgriscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HANG_LIMIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  input  logic [XLEN-1:0] pc_w,
  output logic [XLEN-1:0] last_pc,
  output logic            hang
);

  // The stable count only ever reaches HANG_LIMIT-1 inside a run, because
  // the cycle that would take it further ends the run, so clog2 bits hold it.
  localparam int SW = $clog2(HANG_LIMIT);
  localparam logic [SW-1:0] HANG_TRIP = SW'(HANG_LIMIT - 2);

  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
  logic            first_q, first_d;
  logic            pc_same;

  // The first RUN cycle has no previous PC from this run to compare against,
  // so it can never count as a repeat. From the second cycle on, a repeat is
  // the current PC matching the one registered on the cycle before.
  always_comb begin
    pc_same = !first_q && (pc_w == last_pc_q);
    hang    = advance && pc_same && (stable_cnt_q == HANG_TRIP);
  end

  // stable_cnt holds (number of consecutive equal-PC cycles) - 2 once a run
  // of repeats has started: the first repeat takes it from 0 to 1, so the
  // HANG_LIMIT-th equal cycle is the one that sees HANG_LIMIT-2 registered.
  // A change of PC drops it back to zero. Run entry re-arms everything except
  // last_pc, which keeps showing the previous run until the core moves.
  always_comb begin
    last_pc_d    = last_pc_q;
    stable_cnt_d = stable_cnt_q;
    first_d      = first_q;
    if (clear) begin
      stable_cnt_d = '0;
      first_d      = 1'b1;
    end else if (advance) begin
      last_pc_d = pc_w;
      first_d   = 1'b0;
      if (pc_same) begin
        stable_cnt_d = stable_cnt_q + SW'(1);
      end else begin
        stable_cnt_d = '0;
      end
    end
  end

  // State registers with synchronous reset back to the idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_q    <= '0;
      stable_cnt_q <= '0;
      first_q      <= 1'b1;
    end else begin
      last_pc_q    <= last_pc_d;
      stable_cnt_q <= stable_cnt_d;
      first_q      <= first_d;
    end
  end

  assign last_pc = last_pc_q;

endmodule

// File: rtl/run_monitor.sv
// ---------------------------------------------------------------------------
// run_monitor
//
// Purpose:
//   Run controller and monitor for the single-cycle xgriscv core. Holds the
//   core in reset until a start pulse, lets it run while watching pcW and the
//   fetched instruction, and stops the run on program end (END_PC or ebreak),
//   a cycle-budget timeout, or a hang (PC stuck for HANG_LIMIT cycles). After
//   a run the core is held in reset again and the outcome stays visible.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous active-high reset, overrides all inputs
//   start      in   1      one-cycle request to begin or restart a run
//   pc_w       in   XLEN   core writeback PC
//   instr      in   XLEN   core current instruction
//   core_rst   out  1      active-high reset to the core (high unless RUN)
//   running    out  1      high while in RUN
//   done       out  1      high while in DONE
//   status     out  2      00 none, 01 end, 10 hang, 11 timeout
//   cycle_cnt  out  CNT_W  RUN cycles elapsed, saturating
//   last_pc    out  XLEN   PC sampled on the most recent RUN cycle
// ---------------------------------------------------------------------------
module run_monitor
  import xgriscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] END_PC     = 32'h000000ff,
  parameter int              MAX_CYCLES = 100000,
  parameter int              HANG_LIMIT = 16,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc_w,
  input  logic [XLEN-1:0]  instr,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [XLEN-1:0]  last_pc
);

  // Reject parameter sets the counters cannot represent. A budget that does
  // not fit in CNT_W bits could never be reported in cycle_cnt; an int-sized
  // MAX_CYCLES always fits once CNT_W reaches 31.
  if (MAX_CYCLES < 2) begin : g_bad_max_small
    $error("run_monitor: MAX_CYCLES must be at least 2");
  end
  if (HANG_LIMIT < 2) begin : g_bad_hang_small
    $error("run_monitor: HANG_LIMIT must be at least 2");
  end
  if (XLEN < 32) begin : g_bad_xlen
    $error("run_monitor: XLEN must be at least 32");
  end
  if (CNT_W < 31) begin : g_cnt_range
    if (MAX_CYCLES >= (1 << CNT_W)) begin : g_bad_max_wide
      $error("run_monitor: MAX_CYCLES does not fit in CNT_W bits");
    end
  end

  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_CYCLES - 1);
  localparam logic [XLEN-1:0]  EBREAK = XLEN'(INSTR_EBREAK);

  run_state_e       state_q, state_d;
  run_status_e      status_q, status_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic        in_run;
  logic        run_enter;
  logic        end_hit;
  logic        timeout_hit;
  logic        hang_hit;
  run_status_e term_status;

  // The PC-stability tracking lives in its own block; it only advances on
  // RUN cycles and is re-armed on the edge that enters RUN.
  hang_detector #(
    .XLEN       (XLEN),
    .HANG_LIMIT (HANG_LIMIT)
  ) u_hang_detector (
    .clk     (clk),
    .reset   (reset),
    .clear   (run_enter),
    .advance (in_run),
    .pc_w    (pc_w),
    .last_pc (last_pc),
    .hang    (hang_hit)
  );

  // Termination conditions for the current RUN cycle. The timeout compares
  // the count before this cycle's increment, so the run that trips it shows
  // exactly MAX_CYCLES afterwards. The package helper picks the winner when
  // several fire together.
  always_comb begin
    in_run      = (state_q == RUN);
    end_hit     = (pc_w == END_PC) || (instr == EBREAK);
    timeout_hit = (cycle_cnt_q == MAX_M1);
    term_status = pick_status(end_hit, timeout_hit, hang_hit);
  end

  // Next-state logic. IDLE and DONE behave the same towards start: both
  // launch a fresh run with cleared counters and status. In RUN the counter
  // always advances (including on the terminating cycle) and saturates so a
  // huge budget cannot wrap it; start is ignored there. DONE otherwise just
  // holds the results of the finished run for the bench or board to read.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    cycle_cnt_d = cycle_cnt_q;
    run_enter   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          status_d    = ST_NONE;
          cycle_cnt_d = '0;
          run_enter   = 1'b1;
        end
      end
      RUN: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (term_status != ST_NONE) begin
          state_d  = DONE;
          status_d = term_status;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and result registers. Reset wins over start, so a reset arriving in
  // the same cycle as start, or in the middle of a run, leaves the block idle
  // with no trace of the interrupted run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      status_q    <= ST_NONE;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Control outputs are decoded from the registered state only, so the core
  // reset never glitches with the monitored inputs.
  always_comb begin
    core_rst  = (state_q != RUN);
    running   = (state_q == RUN);
    done      = (state_q == DONE);
    status    = status_q;
    cycle_cnt = cycle_cnt_q;
  end

endmodule

// File: tb/tb_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_run_monitor
//
// Purpose:
//   Self-checking bench for run_monitor. Stimulus tasks drive directed PC /
//   instruction sequences and push the hand-computed end-of-run result into a
//   scoreboard queue; a separate monitor pops and compares it whenever the
//   DUT raises done. Control outputs are also checked directly around start,
//   reset and the DONE hold period. The DUT is built with MAX_CYCLES=80 so a
//   65-cycle program-end walk still fits inside the budget.
// ---------------------------------------------------------------------------
module tb_run_monitor;

  localparam int          XLEN       = 32;
  localparam int          CNT_W      = 32;
  localparam int          MAX_CYCLES = 80;
  localparam int          HANG_LIMIT = 16;
  localparam logic [31:0] NOP        = 32'h00000013;
  localparam logic [31:0] EBREAK     = 32'h00100073;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] cnt;
    logic [31:0] pc;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [XLEN-1:0]  pc_w;
  logic [XLEN-1:0]  instr;
  logic             core_rst;
  logic             running;
  logic             done;
  logic [1:0]       status;
  logic [CNT_W-1:0] cycle_cnt;
  logic [XLEN-1:0]  last_pc;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  run_monitor #(
    .XLEN       (XLEN),
    .END_PC     (32'h000000ff),
    .MAX_CYCLES (MAX_CYCLES),
    .HANG_LIMIT (HANG_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pc_w      (pc_w),
    .instr     (instr),
    .core_rst  (core_rst),
    .running   (running),
    .done      (done),
    .status    (status),
    .cycle_cnt (cycle_cnt),
    .last_pc   (last_pc)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one RUN cycle worth of core inputs and step past the next edge.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins);
    pc_w  = pc;
    instr = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input logic [1:0] st, input logic [31:0] cnt,
                            input logic [31:0] pc);
    exp_t e;
    e.status = st;
    e.cnt    = cnt;
    e.pc     = pc;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle; the core must leave reset on the very next
  // cycle with cleared counters.
  task automatic startRun(input string name);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({name, " core_rst after start"}, 32'(core_rst), 32'd0);
    checkOutput({name, " running after start"}, 32'(running), 32'd1);
    checkOutput({name, " cycle_cnt cleared"}, cycle_cnt, 32'd0);
    checkOutput({name, " status cleared"}, 32'(status), 32'd0);
  endtask

  task automatic checkDone(input string name);
    checkOutput({name, " done"}, 32'(done), 32'd1);
    checkOutput({name, " core_rst re-held"}, 32'(core_rst), 32'd1);
  endtask

  // Monitor: every rising edge of done delivers one run result, compared
  // against the oldest expected result in the scoreboard.
  initial begin
    logic done_seen;
    exp_t e;
    done_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected done: status=%0d cnt=%0d pc=0x%0h, expected no result",
                   status, cycle_cnt, last_pc);
        end else begin
          e = sb.pop_front();
          checkOutput("sb status", 32'(status), 32'(e.status));
          checkOutput("sb cycle_cnt", cycle_cnt, e.cnt);
          checkOutput("sb last_pc", last_pc, e.pc);
        end
      end
      done_seen = done;
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pc_w  = '0;
    instr = NOP;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset core_rst", 32'(core_rst), 32'd1);
    checkOutput("reset running", 32'(running), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset status", 32'(status), 32'd0);
    checkOutput("reset cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("reset last_pc", last_pc, 32'd0);

    // Reset and start together: reset wins, block stays idle.
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    checkOutput("reset+start core_rst", 32'(core_rst), 32'd1);
    checkOutput("reset+start running", 32'(running), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("idle holds running", 32'(running), 32'd0);

    // Program end by PC: 0..0xfc is 64 cycles, 0xff is cycle 65.
    startRun("end");
    pushExpect(2'b01, 32'd65, 32'h000000ff);
    for (int i = 0; i < 64; i++) applyStimulus(32'(i * 4), NOP);
    applyStimulus(32'h000000ff, NOP);
    checkDone("end");

    // Hang: PC 0x40 on cycles 5..20 (16 equal cycles) trips on cycle 20.
    startRun("hang");
    pushExpect(2'b10, 32'd20, 32'h00000040);
    for (int i = 0; i < 4; i++) applyStimulus(32'(i * 4), NOP);
    for (int i = 0; i < 16; i++) applyStimulus(32'h00000040, NOP);
    checkDone("hang");

    // Timeout: ever-changing PC; cycle 80 uses PC 0x1000 + 4*79 = 0x113c.
    startRun("timeout");
    pushExpect(2'b11, 32'd80, 32'h0000113c);
    for (int i = 0; i < 80; i++) applyStimulus(32'h00001000 + 32'(i * 4), NOP);
    checkDone("timeout");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(32'h00002000 + 32'(k * 4), NOP);
      checkOutput("timeout hold done", 32'(done), 32'd1);
      checkOutput("timeout hold status", 32'(status), 32'd3);
      checkOutput("timeout hold cycle_cnt", cycle_cnt, 32'd80);
      checkOutput("timeout hold last_pc", last_pc, 32'h0000113c);
    end

    // ebreak at PC 0x20 (cycle 9); a start pulse on cycle 3 is ignored.
    startRun("ebreak");
    pushExpect(2'b01, 32'd9, 32'h00000020);
    for (int i = 0; i < 8; i++) begin
      start = (i == 2);
      applyStimulus(32'(i * 4), NOP);
    end
    start = 1'b0;
    applyStimulus(32'h00000020, EBREAK);
    checkDone("ebreak");

    // Reset on RUN cycle 7 wipes everything; no result is expected.
    startRun("midreset");
    for (int i = 0; i < 6; i++) applyStimulus(32'h00000300 + 32'(i * 4), NOP);
    reset = 1'b1;
    applyStimulus(32'h00000318, NOP);
    reset = 1'b0;
    checkOutput("midreset core_rst", 32'(core_rst), 32'd1);
    checkOutput("midreset running", 32'(running), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("midreset status", 32'(status), 32'd0);
    checkOutput("midreset last_pc", last_pc, 32'd0);

    // Complete a short run, then restart straight from DONE.
    startRun("short");
    pushExpect(2'b01, 32'd3, 32'h00000008);
    applyStimulus(32'h00000000, NOP);
    applyStimulus(32'h00000004, NOP);
    applyStimulus(32'h00000008, EBREAK);
    checkDone("short");
    startRun("restart");
    pushExpect(2'b01, 32'd2, 32'h00000104);
    applyStimulus(32'h00000100, NOP);
    applyStimulus(32'h00000104, EBREAK);
    checkDone("restart");

    // End PC on the same cycle the budget expires: end wins.
    startRun("end+timeout");
    pushExpect(2'b01, 32'd80, 32'h000000ff);
    for (int i = 0; i < 79; i++) applyStimulus(32'h00003000 + 32'(i * 4), NOP);
    applyStimulus(32'h000000ff, NOP);
    checkDone("end+timeout");

    // ebreak on the cycle that would complete a hang: end wins.
    startRun("end+hang");
    pushExpect(2'b01, 32'd16, 32'h00000080);
    for (int i = 0; i < 15; i++) applyStimulus(32'h00000080, NOP);
    applyStimulus(32'h00000080, EBREAK);
    checkDone("end+hang");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
